// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package mem_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned OFF_W      = $clog2(WORD_BYTES);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_e;

   function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
      return addr[OFF_W-1:0] == '0;
   endfunction

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// Word-bus valid/ack interface between the controller (master) and memory (slave).
interface dmem_bus_ctrl_if;
   import mem_pkg::*;

   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;
   logic              bus_err;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack, bus_err
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack, bus_err
   );

endinterface

// File: rtl/bus_timeout_ctr.sv
// Counts bus wait cycles; expired flags the last cycle the request may be held.
module bus_timeout_ctr #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Saturates at LAST so the count can never wrap.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en && cnt != LAST) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == LAST);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data-memory controller: turns load/store requests into a bus transaction.
module dmem_bus_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memreadM,
   input  logic              memwriteM,
   input  logic [ADDR_W-1:0] aluoutM,
   input  logic [DATA_W-1:0] writedataM,
   output logic [DATA_W-1:0] readdataM,
   output logic              stallM,
   output logic              errM,
   dmem_bus_ctrl_if.master   bus
);

   state_e state;
   logic   legal;
   logic   bad;
   logic   expired;
   logic   cnt_en;
   logic   cnt_clr;

   always_comb begin
      legal   = (memreadM ^ memwriteM) && is_aligned(aluoutM);
      bad     = (memreadM || memwriteM) && !legal;
      stallM  = (state == IDLE && legal) || (state == REQ);
      cnt_en  = (state == REQ) && !bus.bus_ack && !bus.bus_err;
      cnt_clr = (state != REQ);
   end

   bus_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .expired(expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         readdataM     <= '0;
         errM          <= 1'b0;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= '0;
         bus.bus_wdata <= '0;
      end else begin
         errM <= 1'b0;
         case (state)
            IDLE: begin
               if (legal) begin
                  bus.bus_req   <= 1'b1;
                  bus.bus_we    <= memwriteM;
                  bus.bus_addr  <= {aluoutM[ADDR_W-1:OFF_W], OFF_W'(0)};
                  bus.bus_wdata <= writedataM;
                  state         <= REQ;
               end else if (bad) begin
                  errM <= 1'b1;
               end
            end
            REQ: begin
               // Error wins over a simultaneous ack; timeout aborts like an error.
               if (bus.bus_err || (!bus.bus_ack && expired)) begin
                  errM        <= 1'b1;
                  readdataM   <= '0;
                  bus.bus_req <= 1'b0;
                  state       <= DONE;
               end else if (bus.bus_ack) begin
                  if (!bus.bus_we) begin
                     readdataM <= bus.bus_rdata;
                  end
                  bus.bus_req <= 1'b0;
                  state       <= DONE;
               end
            end
            DONE: begin
               // Same instruction is still presented here; ignore it to avoid a re-issue.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dmem_bus_ctrl.md
# dmem_bus_ctrl

MEM-stage data-memory controller sitting directly downstream of the pipelined datapath. It consumes the datapath's `aluoutM` address and `writedataM` store data, runs a valid/ack transaction on an external word bus, and returns `readdataM`, which the MEM/WB register captures. It also drives `stallM`, which freezes the pipeline while a transaction is in flight, and flags misaligned, illegal, failed or timed-out accesses.

## Interface
- `TIMEOUT`, default 15: maximum cycles `bus_req` is held waiting for `bus_ack`; legal range ≥1.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  synchronous, active-high.
- `memreadM`  in  1  load in MEM stage.
- `memwriteM`  in  1  store in MEM stage.
- `aluoutM`  in  32  byte address.
- `writedataM`  in  32  store data.
- `readdataM`  out  32  load data, registered.
- `stallM`  out  1  hold IF..MEM pipeline registers.
- `errM`  out  1  one-cycle pulse on a failed or dropped access.
- `bus_req`  out  1  transaction valid, registered.
- `bus_we`  out  1  1 = write, registered.
- `bus_addr`  out  32  word-aligned address, registered.
- `bus_wdata`  out  32  write data, registered.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.
- `bus_ack`  in  1  transaction complete.
- `bus_err`  in  1  slave error.

## Operation
- The state machine has three states: IDLE, REQ and DONE. Reset enters IDLE.
- **IDLE, legal access:**
  - Trigger: `memreadM` xor `memwriteM` is 1 and `aluoutM[1:0]`=0.
  - Action: `stallM`=1 combinationally, and the bus outputs are latched.
    - `bus_addr`={`aluoutM[31:2]`,2'b00}.
    - `bus_we`=`memwriteM`.
    - `bus_wdata`=`writedataM`.
  - Next state: REQ.
- **IDLE, misaligned access** (`aluoutM[1:0]`≠0) **or illegal access** (read and write both 1):
  - No bus transaction and no stall.
  - `errM`=1 on the next cycle.
  - Stays in IDLE. `readdataM` is unchanged.
- **REQ:**
  - `bus_req`=1 and `stallM`=1.
  - The timeout counter increments on every REQ cycle without an ack or error.
- **REQ exits** (evaluated at the clock edge):
  - `bus_err`=1: `errM` pulses, `readdataM`←0, go to DONE. `bus_err` takes priority over a simultaneous `bus_ack`.
  - `bus_ack`=1: for a read, `readdataM`←`bus_rdata`; for a write, `readdataM` is unchanged. Go to DONE.
  - Counter = TIMEOUT-1 with no ack: abort, `errM` pulses, `readdataM`←0, go to DONE.
- **DONE:**
  - `bus_req`=0 and `stallM`=0, so the pipeline advances at the end of this cycle.
  - Inputs are ignored, because the same instruction is still presented. This prevents a re-issue.
  - Next state: IDLE.
- `bus_ack` or `bus_err` seen while `bus_req`=0 is ignored.
- Bus outputs stay stable for the whole REQ state.
- Reset in any state takes effect at the next edge:
  - State goes to IDLE and the counter clears.
  - All outputs go to 0.
  - An in-flight transaction is abandoned and `errM` is not pulsed.

## Timing
- **Reset values:** `readdataM`=0, `stallM`=0 (combinational from IDLE with no access), `errM`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0.
- **Access cycle sequence**, for an access first presented in cycle N:
  - Cycle N: IDLE, `stallM`=1.
  - Cycle N+1: first `bus_req` cycle.
  - Ack seen in cycle M (M ≥ N+1): DONE in M+1, and `readdataM` is valid in M+1.
- Minimum MEM occupancy with a zero-wait ack is 3 cycles, with 2 stall cycles.
- Maximum `bus_req` duration is TIMEOUT cycles, so worst-case MEM occupancy is TIMEOUT+2.
- `errM` pulses are exactly one cycle wide:
  - Abort (bus error or timeout): asserted in the DONE cycle.
  - Misaligned or illegal access: asserted in the cycle after IDLE.
- Back-to-back accesses: the earliest next issue is the IDLE cycle following DONE.
- The counter width is $clog2(TIMEOUT+1) and it never wraps.

## Structure
- **Shared package `mem_pkg`:**
  - State enum {IDLE, REQ, DONE}.
  - Constants: WORD_BYTES=4, ADDR_W=32, DATA_W=32.
- **Sub-module `bus_timeout_ctr`:**
  - Ports: `clk`, `reset`, `clr`, `en`, `expired`.
  - Parameter: TIMEOUT.
  - Instantiated once.
- Everything else is in a single FSM module.

## Test plan
- **Aligned load, zero-wait:** `memreadM`=1, `aluoutM`=0x104, slave acks in the first REQ cycle with 0xDEADBEEF. Required: `bus_addr`=0x104, `stallM` high 2 cycles, `readdataM`=0xDEADBEEF in the DONE cycle, exactly one `bus_req` transaction.
- **Store with 3 wait states:** `memwriteM`=1, `aluoutM`=0x20, `writedataM`=0x55AA. Required: `bus_we`=1 and `bus_wdata`=0x55AA held for 4 `bus_req` cycles, `stallM` high 5 cycles, `readdataM` unchanged, `errM`=0.
- **Timeout, TIMEOUT=15, no ack:** required: `bus_req` high exactly 15 cycles, then DONE with `errM`=1 and `readdataM`=0, then IDLE.
- **`bus_ack` and `bus_err` high together:** required: error path taken, `errM`=1, `readdataM`=0.
- **Misaligned load** (`aluoutM`=0x103): required: no `bus_req`, `stallM`=0, `errM` pulse next cycle. Then with read and write both 1: same response.
- **Reset mid-REQ, 2nd wait cycle:** required: `bus_req`=0 the following cycle, all outputs 0, no `errM`, and a subsequent load completes normally.
